in_port_fifo: RTL and testbench

- Input-port block for the five-stage pipeline. It is the counterpart of the OUT port: it carries data from an external device into the processor.
- The external device pushes words with a valid/ready handshake into a small circular FIFO.
- The IN instruction, in the memory/write-back path, reads the head word combinationally and pops it with read_enable.
- Status flags let software and hazard logic know whether data is available.

---
 rtl/in_port_fifo.sv | 101 ++++++++++
 tb/tb_in_port_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : in_port_fifo
// Brief    : External-device input port; valid/ready push into a circular
//            FIFO, zero-latency head read and pop for the IN instruction.
// Revision : 1.0 - initial release
// ============================================================================
module in_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ext_data,
    input  logic                     ext_valid,
    output logic                     ext_ready,
    input  logic                     read_enable,
    output logic [WIDTH-1:0]         read_data,
    output logic                     data_avail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow,
    input  logic                     clear_underflow
);

    localparam int             c_aw         = $clog2(DEPTH);
    localparam int             c_cw         = c_aw + 1;
    localparam logic [c_cw-1:0] c_full_count = c_cw'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic             underflow_q, underflow_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come from the occupancy counter so pointer equality never matters.
    assign w_full  = (count_q == c_full_count);
    assign w_empty = (count_q == '0);
    assign w_push  = ext_valid && !w_full;
    assign w_pop   = read_enable && !w_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_aw'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_aw'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase

        // An underflowing read takes priority over a same-cycle clear.
        if (read_enable && w_empty) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    assign ext_ready  = !w_full;
    assign data_avail = !w_empty;
    assign count      = count_q;
    assign underflow  = underflow_q;
    assign read_data  = w_empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_port_fifo
// Brief    : Self-checking bench for in_port_fifo: vector table plus
//            scoreboard model, with hand-written reset and wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_in_port_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ext_data = '0;
    logic        ext_valid = 1'b0;
    logic        ext_ready;
    logic        read_enable = 1'b0;
    logic [15:0] read_data;
    logic        data_avail;
    logic [2:0]  count;
    logic        underflow;
    logic        clear_underflow = 1'b0;

    in_port_fifo #(.WIDTH(16), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .ext_data        (ext_data),
        .ext_valid       (ext_valid),
        .ext_ready       (ext_ready),
        .read_enable     (read_enable),
        .read_data       (read_data),
        .data_avail      (data_avail),
        .count           (count),
        .underflow       (underflow),
        .clear_underflow (clear_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        re;
        logic        cu;
        int          exp_cnt;
        logic [15:0] exp_rd;
        logic        exp_uf;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    int          mcnt = 0;
    logic        muf  = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic re,
                                input logic cu, input int c, input logic [15:0] rd,
                                input logic uf);
        vec_t t;
        t.v = v; t.d = d; t.re = re; t.cu = cu;
        t.exp_cnt = c; t.exp_rd = rd; t.exp_uf = uf;
        return t;
    endfunction

    // One clock of stimulus; the scoreboard checks the popped head before the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic re, input logic cu);
        logic acc_push, acc_pop, was_empty;
        @(negedge clk);
        ext_valid = v; ext_data = d; read_enable = re; clear_underflow = cu;
        #1;
        chk("pre_count", 32'(count), 32'(mcnt));
        if (re && mcnt > 0)
            chk("pop_data", 32'(read_data), 32'(sb[0]));
        else if (mcnt == 0)
            chk("empty_rdata", 32'(read_data), 32'h0);
        was_empty = (mcnt == 0);
        acc_pop   = re && (mcnt > 0);
        acc_push  = v && (mcnt < 4);
        if (acc_pop)  void'(sb.pop_front());
        if (acc_push) sb.push_back(d);
        mcnt = mcnt + int'(acc_push) - int'(acc_pop);
        if (re && was_empty) muf = 1'b1;
        else if (cu)         muf = 1'b0;
        @(posedge clk);
        #1;
        chk("post_count", 32'(count), 32'(mcnt));
        chk("post_underflow", 32'(underflow), 32'(muf));
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ready", 32'(ext_ready), 32'h1);
        chk("rst_avail", 32'(data_avail), 32'h0);
        chk("rst_rdata", 32'(read_data), 32'h0);
        chk("rst_uf", 32'(underflow), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //             v  data      re cu cnt rd_after  uf
        tbl.push_back(mk(1, 16'h1111, 0, 0, 1, 16'h1111, 0));
        tbl.push_back(mk(1, 16'h2222, 0, 0, 2, 16'h1111, 0));
        tbl.push_back(mk(1, 16'h3333, 0, 0, 3, 16'h1111, 0));
        tbl.push_back(mk(1, 16'h4444, 0, 0, 4, 16'h1111, 0));
        tbl.push_back(mk(1, 16'h5555, 0, 0, 4, 16'h1111, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 3, 16'h2222, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 2, 16'h3333, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h4444, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h7E7E, 1, 0, 1, 16'h7E7E, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h7E7E, 0));
        tbl.push_back(mk(1, 16'hAAA1, 0, 0, 2, 16'h7E7E, 0));
        tbl.push_back(mk(1, 16'hBEEF, 1, 0, 2, 16'hAAA1, 0));
        tbl.push_back(mk(1, 16'hC001, 0, 0, 3, 16'hAAA1, 0));
        tbl.push_back(mk(1, 16'hC002, 0, 0, 4, 16'hAAA1, 0));
        tbl.push_back(mk(1, 16'hC003, 1, 0, 3, 16'hBEEF, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 2, 16'hC001, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hC002, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].re, tbl[i].cu);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_ready", i), 32'(ext_ready), 32'(tbl[i].exp_cnt != 4));
            chk($sformatf("tbl%0d_avail", i), 32'(data_avail), 32'(tbl[i].exp_cnt != 0));
            chk($sformatf("tbl%0d_rdata", i), 32'(read_data), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_uf", i), 32'(underflow), 32'(tbl[i].exp_uf));
        end

        // Wrap-around with one word outstanding
        step(1, 16'h0001, 0, 0);
        for (int k = 2; k <= 10; k++) begin
            step(1, 16'(k), 1, 0);
            chk("wrap_count", 32'(count), 32'h1);
            chk("wrap_head", 32'(read_data), 32'(k));
        end
        step(0, 16'h0000, 1, 0);
        chk("wrap_drained", 32'(count), 32'h0);

        // Asynchronous reset mid-run with three words stored
        step(1, 16'hD001, 0, 0);
        step(1, 16'hD002, 0, 0);
        step(1, 16'hD003, 0, 0);
        @(negedge clk);
        ext_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_avail", 32'(data_avail), 32'h0);
        chk("arst_ready", 32'(ext_ready), 32'h1);
        chk("arst_rdata", 32'(read_data), 32'h0);
        sb.delete();
        mcnt = 0;
        muf  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1, 16'h00AA, 0, 0);
        chk("after_rst_rdata", 32'(read_data), 32'h00AA);
        step(0, 16'h0000, 1, 0);
        chk("after_rst_empty", 32'(read_data), 32'h0);

        @(negedge clk);
        read_enable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
